// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the pipelined float comparator.
// Op encodings, ordering-flag bundle and zero classification.
package fp_cmp_pkg;

    localparam logic [2:0] OP_GT = 3'd0;
    localparam logic [2:0] OP_GE = 3'd1;
    localparam logic [2:0] OP_LT = 3'd2;
    localparam logic [2:0] OP_LE = 3'd3;
    localparam logic [2:0] OP_EQ = 3'd4;
    localparam logic [2:0] OP_NE = 3'd5;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } ord_t;

    // A zero mantissa is zero whatever the sign and exponent.
    function automatic logic is_zero(input logic [63:0] mant);
        return mant == '0;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over a mantissa, used for normalising keys.
// Result is 0..MAN_W-1; an all-zero input yields MAN_W-1 or 0 (don't care).
module fp_lzc #(
    parameter int MAN_W = 8,
    localparam int LZ_W = (MAN_W > 1) ? $clog2(MAN_W) : 1
) (
    input  logic [MAN_W-1:0] mant,
    output logic [LZ_W-1:0]  lz
);

    always_comb begin
        lz = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (mant[i]) lz = LZ_W'(MAN_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage valid/ready float comparator: S1 classifies, S2 orders.
// Define FPCMP_NORM_EN to normalise operands before comparing.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W = 4,
    parameter int MAN_W = 8,
    localparam int FW = 1 + EXP_W + MAN_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [FW-1:0] i_float1,
    input  logic [FW-1:0] i_float2,
    input  logic [2:0]    i_op,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_res,
    output logic          o_lt,
    output logic          o_eq,
    output logic          o_gt,
    output logic          o_op_err
);

    localparam int KE = EXP_W + 1;

    typedef struct packed {
        logic             s;
        logic             z;
        logic [KE-1:0]    e;
        logic [MAN_W-1:0] m;
    } key_t;

    logic             sa, sb;
    logic [EXP_W-1:0] xa, xb;
    logic [MAN_W-1:0] ma, mb;
    logic [KE-1:0]    kea, keb;
    logic [MAN_W-1:0] kma, kmb;
    key_t             ka, kb;

    assign {sa, xa, ma} = i_float1;
    assign {sb, xb, mb} = i_float2;

`ifdef FPCMP_NORM_EN
    localparam int LZ_W = (MAN_W > 1) ? $clog2(MAN_W) : 1;
    logic [LZ_W-1:0] lza, lzb;

    fp_lzc #(.MAN_W(MAN_W)) u_lzc_a (.mant(ma), .lz(lza));
    fp_lzc #(.MAN_W(MAN_W)) u_lzc_b (.mant(mb), .lz(lzb));

    // Exponent may go negative after normalising, hence the extra sign bit.
    assign kea = KE'(xa) - KE'(lza);
    assign keb = KE'(xb) - KE'(lzb);
    assign kma = ma << lza;
    assign kmb = mb << lzb;
`else
    assign kea = KE'(xa);
    assign keb = KE'(xb);
    assign kma = ma;
    assign kmb = mb;
`endif

    assign ka = {sa, is_zero(64'(ma)), kea, kma};
    assign kb = {sb, is_zero(64'(mb)), keb, kmb};

    logic       s1_valid;
    key_t       s1_a, s1_b;
    logic [2:0] s1_op;
    logic       s2_adv;

    assign s2_adv  = !o_valid || i_ready;
    assign o_ready = !s1_valid || s2_adv;

    logic mag_gt, mag_eq;
    ord_t ord;
    logic res_d, err_d;

    assign mag_eq = (s1_a.e == s1_b.e) && (s1_a.m == s1_b.m);
    assign mag_gt = ($signed(s1_a.e) > $signed(s1_b.e)) ||
                    ((s1_a.e == s1_b.e) && (s1_a.m > s1_b.m));

    always_comb begin
        ord = '0;
        unique case (1'b1)
            s1_a.z && s1_b.z: ord.eq = 1'b1;
            s1_a.z && !s1_b.z: begin
                ord.gt = s1_b.s;
                ord.lt = !s1_b.s;
            end
            !s1_a.z && s1_b.z: begin
                ord.lt = s1_a.s;
                ord.gt = !s1_a.s;
            end
            !s1_a.z && !s1_b.z && (s1_a.s != s1_b.s): begin
                ord.lt = s1_a.s;
                ord.gt = !s1_a.s;
            end
            !s1_a.z && !s1_b.z && (s1_a.s == s1_b.s): begin
                ord.eq = mag_eq;
                ord.gt = !mag_eq && (mag_gt ^ s1_a.s);
                ord.lt = !mag_eq && !(mag_gt ^ s1_a.s);
            end
            default: ord = '0;
        endcase
    end

    always_comb begin
        res_d = 1'b0;
        err_d = 1'b0;
        unique case (s1_op)
            OP_GT: res_d = ord.gt;
            OP_GE: res_d = ord.gt || ord.eq;
            OP_LT: res_d = ord.lt;
            OP_LE: res_d = ord.lt || ord.eq;
            OP_EQ: res_d = ord.eq;
            OP_NE: res_d = !ord.eq;
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            o_valid  <= 1'b0;
            o_res    <= 1'b0;
            o_lt     <= 1'b0;
            o_eq     <= 1'b0;
            o_gt     <= 1'b0;
            o_op_err <= 1'b0;
        end else begin
            if (o_ready) begin
                s1_valid <= i_valid;
                if (i_valid) begin
                    s1_a  <= ka;
                    s1_b  <= kb;
                    s1_op <= i_op;
                end
            end
            if (s2_adv) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_res    <= res_d;
                    o_lt     <= ord.lt;
                    o_eq     <= ord.eq;
                    o_gt     <= ord.gt;
                    o_op_err <= err_d;
                end
            end
        end
    end

endmodule
